// File: rtl/display_share_ctrl_pkg.sv
// Shared definitions for the display sharing controller.
// Holds the scan FSM state encoding, the active-low anode patterns for the
// four digits, the nibble width and small helpers for selecting an anode
// pattern or a nibble by digit index.
package display_share_ctrl_pkg;

    localparam int NIB_W = 4;

    localparam logic [3:0] AN_OFF  = 4'b1111;
    localparam logic [3:0] AN_DIG3 = 4'b0111;
    localparam logic [3:0] AN_DIG2 = 4'b1011;
    localparam logic [3:0] AN_DIG1 = 4'b1101;
    localparam logic [3:0] AN_DIG0 = 4'b1110;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } scan_state_e;

    function automatic logic [3:0] an_for_digit(input logic [1:0] digit);
        logic [3:0] pat;
        case (digit)
            2'd3:    pat = AN_DIG3;
            2'd2:    pat = AN_DIG2;
            2'd1:    pat = AN_DIG1;
            default: pat = AN_DIG0;
        endcase
        return pat;
    endfunction

    function automatic logic [NIB_W-1:0] nibble_sel(input logic [4*NIB_W-1:0] word,
                                                     input logic [1:0]         digit);
        logic [NIB_W-1:0] nib;
        case (digit)
            2'd3:    nib = word[4*NIB_W-1:3*NIB_W];
            2'd2:    nib = word[3*NIB_W-1:2*NIB_W];
            2'd1:    nib = word[2*NIB_W-1:NIB_W];
            default: nib = word[NIB_W-1:0];
        endcase
        return nib;
    endfunction

endpackage

// File: rtl/display_share_ctrl_digit_scan_seq.sv
// digit_scan_seq: BLANK/SHOW digit sequencer for a 4-digit multiplexed display.
// A frame walks digit 3 down to digit 0; each digit spends BLANK ticks with all
// anodes off, then DWELL ticks lit.
// Ports:
//   clk, rst        clock, synchronous active-low reset
//   tick            scan-rate enable; nothing advances without it
//   start           begin a frame from IDLE, or chain a new frame at frame end
//   digit           current digit index (3..0)
//   an              active-low anode enables
//   frame_end       high during the last SHOW tick slot of digit 0 (not tick-gated)
//
// state    | meaning
// ---------+------------------------------------------------
// ST_IDLE  | no frame in progress, anodes off
// ST_BLANK | anodes off ahead of the current digit
// ST_SHOW  | current digit lit for DWELL ticks
module digit_scan_seq
    import display_share_ctrl_pkg::*;
#(
    parameter int unsigned DWELL = 4,
    parameter int unsigned BLANK = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       start,
    output logic [1:0] digit,
    output logic [3:0] an,
    output logic       frame_end
);

    localparam int unsigned CNT_MAX = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int CW = $clog2(CNT_MAX + 1);

    scan_state_e    state_q, state_d;
    logic [1:0]     digit_q, digit_d;
    logic [CW-1:0]  cnt_q,   cnt_d;

    always_comb begin
        state_d = state_q;
        digit_d = digit_q;
        cnt_d   = cnt_q;
        if (tick) begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d = ST_BLANK;
                        digit_d = 2'd3;
                        cnt_d   = '0;
                    end
                end
                ST_BLANK: begin
                    if (cnt_q == CW'(BLANK - 1)) begin
                        state_d = ST_SHOW;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ST_SHOW: begin
                    if (cnt_q == CW'(DWELL - 1)) begin
                        cnt_d = '0;
                        if (digit_q == 2'd0) begin
                            // Frame boundary: chain straight into the next frame
                            // when the arbiter keeps a grant, else go idle.
                            if (start) begin
                                state_d = ST_BLANK;
                                digit_d = 2'd3;
                            end else begin
                                state_d = ST_IDLE;
                                digit_d = 2'd0;
                            end
                        end else begin
                            state_d = ST_BLANK;
                            digit_d = digit_q - 2'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    digit_d = 2'd0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            digit_q <= 2'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            digit_q <= digit_d;
            cnt_q   <= cnt_d;
        end
    end

    assign digit     = digit_q;
    assign an        = (state_q == ST_SHOW) ? an_for_digit(digit_q) : AN_OFF;
    assign frame_end = (state_q == ST_SHOW) && (digit_q == 2'd0) &&
                       (cnt_q == CW'(DWELL - 1));

endmodule

// File: rtl/display_share_ctrl.sv
// display_share_ctrl: shares one 4-digit 7-segment display between two
// requesters. Ownership is decided only at grant time from idle or at frame
// boundaries, and the displayed word is snapshotted at those same points so a
// frame never tears.
// Ports:
//   clk, rst          clock, synchronous active-low reset
//   tick              scan-rate enable
//   req_a, req_b      display requests
//   data_a, data_b    four nibbles each, [15:12] on digit 3
//   gnt_a, gnt_b      current owner (one-hot or none)
//   char              nibble for the segment decoder
//   an                active-low anode enables, an[3] leftmost
//   scan_done         one-cycle pulse on the final tick of a frame
module display_share_ctrl
    import display_share_ctrl_pkg::*;
#(
    parameter int unsigned DWELL = 4,
    parameter int unsigned BLANK = 1,
    parameter int unsigned HOLD  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        req_a,
    input  logic        req_b,
    input  logic [15:0] data_a,
    input  logic [15:0] data_b,
    output logic        gnt_a,
    output logic        gnt_b,
    output logic [3:0]  char,
    output logic [3:0]  an,
    output logic        scan_done
);

    localparam int FW = $clog2(HOLD + 1);

    logic           gnt_a_q,  gnt_a_d;
    logic           gnt_b_q,  gnt_b_d;
    logic           ptr_q,    ptr_d;      // 0: A wins a tie, 1: B wins a tie
    logic [FW-1:0]  frames_q, frames_d;
    logic [15:0]    snap_q,   snap_d;

    logic           idle;
    logic           seq_start;
    logic [1:0]     seq_digit;
    logic           seq_frame_end;
    logic           pick_b;
    logic           own_b;
    logic           own_req;
    logic           oth_req;

    assign idle = !(gnt_a_q || gnt_b_q);

    digit_scan_seq #(
        .DWELL (DWELL),
        .BLANK (BLANK)
    ) u_scan (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .start     (seq_start),
        .digit     (seq_digit),
        .an        (an),
        .frame_end (seq_frame_end)
    );

    always_comb begin
        gnt_a_d   = gnt_a_q;
        gnt_b_d   = gnt_b_q;
        ptr_d     = ptr_q;
        frames_d  = frames_q;
        snap_d    = snap_q;
        seq_start = 1'b0;
        pick_b    = req_b && (!req_a || ptr_q);
        own_b     = gnt_b_q;
        own_req   = own_b ? req_b : req_a;
        oth_req   = own_b ? req_a : req_b;

        if (tick) begin
            if (idle) begin
                if (req_a || req_b) begin
                    gnt_a_d   = !pick_b;
                    gnt_b_d   = pick_b;
                    ptr_d     = !pick_b;
                    frames_d  = FW'(1);
                    snap_d    = pick_b ? data_b : data_a;
                    seq_start = 1'b1;
                end
            end else if (seq_frame_end) begin
                if (own_req && (!oth_req || (frames_q < FW'(HOLD)))) begin
                    if (frames_q < FW'(HOLD)) begin
                        frames_d = frames_q + FW'(1);
                    end
                    snap_d    = own_b ? data_b : data_a;
                    seq_start = 1'b1;
                end else if (oth_req) begin
                    // Hand over; the tie pointer now favours the side just released.
                    gnt_a_d   = own_b;
                    gnt_b_d   = !own_b;
                    ptr_d     = own_b;
                    frames_d  = FW'(1);
                    snap_d    = own_b ? data_a : data_b;
                    seq_start = 1'b1;
                end else begin
                    gnt_a_d  = 1'b0;
                    gnt_b_d  = 1'b0;
                    frames_d = '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            gnt_a_q  <= 1'b0;
            gnt_b_q  <= 1'b0;
            ptr_q    <= 1'b0;
            frames_q <= '0;
            snap_q   <= '0;
        end else begin
            gnt_a_q  <= gnt_a_d;
            gnt_b_q  <= gnt_b_d;
            ptr_q    <= ptr_d;
            frames_q <= frames_d;
            snap_q   <= snap_d;
        end
    end

    assign gnt_a     = gnt_a_q;
    assign gnt_b     = gnt_b_q;
    assign char      = idle ? '0 : nibble_sel(snap_q, seq_digit);
    // Gated by rst so a frame aborted by reset never reports completion.
    assign scan_done = rst && tick && seq_frame_end;

endmodule

// File: tb/tb_display_share_ctrl.sv
module tb_display_share_ctrl;

    localparam int DW = 2;
    localparam int BL = 1;
    localparam int HD = 2;
    localparam int SLOT = BL + DW;
    localparam int FL = 4 * SLOT;

    logic        clk = 1'b0;
    logic        rst, tick, req_a, req_b;
    logic [15:0] data_a, data_b;
    logic        gnt_a, gnt_b, scan_done;
    logic [3:0]  char, an;

    int checks = 0;
    int errors = 0;

    // Reference model: owner 0=none 1=A 2=B, pos = ticks elapsed in the frame.
    int          m_owner, m_pos, m_frames, m_ptr;
    logic [15:0] m_snap;

    display_share_ctrl #(.DWELL(DW), .BLANK(BL), .HOLD(HD)) dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .req_a     (req_a),
        .req_b     (req_b),
        .data_a    (data_a),
        .data_b    (data_b),
        .gnt_a     (gnt_a),
        .gnt_b     (gnt_b),
        .char      (char),
        .an        (an),
        .scan_done (scan_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner  = 0;
        m_pos    = 0;
        m_frames = 0;
        m_ptr    = 1;
        m_snap   = 16'h0;
    endtask

    task automatic model_edge();
        bit own_req, oth_req;
        if (!rst) begin
            model_reset();
        end else if (tick) begin
            if (m_owner == 0) begin
                if (req_a || req_b) begin
                    if (req_a && req_b) m_owner = m_ptr;
                    else                m_owner = req_a ? 1 : 2;
                    m_ptr    = 3 - m_owner;
                    m_frames = 1;
                    m_snap   = (m_owner == 1) ? data_a : data_b;
                    m_pos    = 0;
                end
            end else if (m_pos == FL - 1) begin
                own_req = (m_owner == 1) ? req_a : req_b;
                oth_req = (m_owner == 1) ? req_b : req_a;
                if (own_req && (!oth_req || m_frames < HD)) begin
                    if (m_frames < HD) m_frames++;
                    m_snap = (m_owner == 1) ? data_a : data_b;
                end else if (oth_req) begin
                    m_ptr    = m_owner;
                    m_owner  = 3 - m_owner;
                    m_frames = 1;
                    m_snap   = (m_owner == 1) ? data_a : data_b;
                end else begin
                    m_owner  = 0;
                    m_frames = 0;
                end
                m_pos = 0;
            end else begin
                m_pos++;
            end
        end
    endtask

    task automatic check_outputs();
        logic [3:0] e_an, e_char;
        logic       e_ga, e_gb, e_sd;
        int         dig;
        if (m_owner == 0) begin
            e_an   = 4'hF;
            e_char = 4'h0;
        end else begin
            dig    = 3 - m_pos / SLOT;
            e_an   = ((m_pos % SLOT) < BL) ? 4'hF : ~(4'b0001 << dig);
            e_char = 4'((m_snap >> (4 * dig)) & 16'hF);
        end
        e_ga = (m_owner == 1);
        e_gb = (m_owner == 2);
        e_sd = rst && tick && (m_owner != 0) && (m_pos == FL - 1);
        chk("an", an, e_an);
        chk("char", char, e_char);
        chk("gnt_a", gnt_a, e_ga);
        chk("gnt_b", gnt_b, e_gb);
        chk("scan_done", scan_done, e_sd);
    endtask

    task automatic step();
        #1;
        check_outputs();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic wait_done(input string tag);
        bit found = 1'b0;
        for (int k = 0; k < 4 * FL && !found; k++) begin
            #1;
            if (scan_done === 1'b1) found = 1'b1;
            else step();
        end
        chk(tag, found, 1);
    endtask

    logic [3:0]  an_tab [12] = '{4'hF, 4'h7, 4'h7, 4'hF, 4'hB, 4'hB,
                                 4'hF, 4'hD, 4'hD, 4'hF, 4'hE, 4'hE};
    logic [1:0]  share_pat [6] = '{2'b10, 2'b10, 2'b01, 2'b01, 2'b10, 2'b10};

    initial begin
        logic [15:0] word;
        int          dig;

        rst = 1'b0; tick = 1'b1; req_a = 1'b1; req_b = 1'b0;
        data_a = 16'h0; data_b = 16'h0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        repeat (3) step();

        // Single owner with a mid-frame data change.
        rst = 1'b1; data_a = 16'h1234;
        step();
        for (int i = 0; i < 24; i++) begin
            if (i == 4) data_a = 16'hABCD;
            word = (i < 12) ? 16'h1234 : 16'hABCD;
            dig  = 3 - (i % 12) / 3;
            #1;
            chk("dir_an", an, an_tab[i % 12]);
            chk("dir_char", char, (word >> (4 * dig)) & 16'hF);
            chk("dir_done", scan_done, (i % 12 == 11));
            chk("dir_gnt_a", gnt_a, 1);
            step();
        end

        // Release with nobody else waiting.
        repeat (5) step();
        req_a = 1'b0;
        repeat (7) step();
        #1;
        chk("rel_an", an, 4'hF);
        chk("rel_gnt", {gnt_a, gnt_b}, 2'b00);

        // Release with B waiting.
        req_a = 1'b1; data_b = 16'h5678;
        repeat (6) step();
        req_a = 1'b0; req_b = 1'b1;
        wait_done("rel_b_done");
        step();
        #1;
        chk("rel_b_gnt", {gnt_a, gnt_b}, 2'b01);

        // Reset, then both requesting from idle.
        rst = 1'b0; req_a = 1'b0; req_b = 1'b0;
        step();
        rst = 1'b1; req_a = 1'b1; req_b = 1'b1;
        data_a = 16'h0A0A; data_b = 16'h0B0B;
        for (int f = 0; f < 6; f++) begin
            wait_done("share_done");
            chk("share_owner", {gnt_a, gnt_b}, share_pat[f]);
            step();
        end

        // Freeze mid-SHOW, then reset while frozen.
        repeat (4) step();
        tick = 1'b0;
        repeat (5) step();
        rst = 1'b0;
        step();
        rst = 1'b1; tick = 1'b1;
        step();

        // Randomised traffic.
        for (int c = 0; c < 3000; c++) begin
            tick = ($urandom_range(0, 9) < 7);
            rst  = ($urandom_range(0, 249) != 0);
            if ($urandom_range(0, 19) == 0) req_a = ~req_a;
            if ($urandom_range(0, 19) == 0) req_b = ~req_b;
            if ($urandom_range(0, 3) == 0) data_a = 16'($urandom);
            if ($urandom_range(0, 3) == 0) data_b = 16'($urandom);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/display_share_ctrl.md
DISPLAY_SHARE_CTRL -- requirements
Module: display_share_ctrl

Interface
REQ-001 Parameter DWELL, default 4: ticks each digit is lit; legal range >=1.
REQ-002 Parameter BLANK, default 1: ticks all anodes are off before each digit; legal range >=1.
REQ-003 Parameter HOLD, default 2: minimum frames an owner keeps the display while the other requester waits; legal range >=1.
REQ-004 clk  in  1  single clock; all state changes on posedge clk.
REQ-005 rst  in  1  reset, synchronous, active-low.
REQ-006 tick  in  1  scan-rate enable; the FSM advances only on cycles with tick=1.
REQ-007 req_a, req_b  in  1 each  display requests from requesters A and B.
REQ-008 data_a, data_b  in  16 each  four BCD/hex nibbles; [15:12] goes to digit 3, [3:0] to digit 0.
REQ-009 gnt_a, gnt_b  out  1 each  current owner; at most one is high.
REQ-010 char  out  4  nibble for the 7-segment decoder.
REQ-011 an  out  4  anode enables, active-low; an[3] is the leftmost digit.
REQ-012 scan_done  out  1  one-cycle pulse at each frame end.

Function
REQ-013 The FSM SHALL have three states: IDLE, BLANK, SHOW. It SHALL also hold a 2-bit digit index, a tick counter, a frame counter, a 16-bit snapshot and an RR pointer.
REQ-014 In IDLE, the block SHALL drive an=1111, char=0000 and gnt=00.
REQ-015 In IDLE, on a tick with any request: grant the requester, picking the pointer side when both request; load the snapshot from that requester's data; enter BLANK with digit=3. Outputs appear the next cycle.
REQ-016 In BLANK: an=1111 and char=snapshot nibble[digit]. After BLANK ticks, the FSM SHALL go to SHOW with the counter cleared.
REQ-017 In SHOW: an=0111/1011/1101/1110 for digit 3/2/1/0 and char=snapshot nibble[digit]. After DWELL ticks, the FSM SHALL go to BLANK of digit-1.
REQ-018 A frame ends on the last SHOW tick of digit 0. Frame length = 4*(BLANK+DWELL) ticks.
REQ-019 At frame end the block SHALL pulse scan_done for exactly one cycle and then arbitrate.
REQ-020 Arbitration at frame end SHALL follow this order:
- Owner still requesting and other idle: keep the owner.
- Both requesting and frames owned < HOLD: keep the owner.
- Both requesting and frames owned >= HOLD: switch to the other requester.
- Owner dropped and other requesting: switch.
- Neither requesting: go to IDLE with gnt=00.
REQ-021 On each owner change, the frame counter SHALL reset to 1 and the pointer SHALL move to the side not granted.
REQ-022 When keeping the owner, the frame counter SHALL increment and saturate at HOLD.
REQ-023 The snapshot SHALL load only at a grant or at a frame boundary. Data or req changes mid-frame SHALL NOT alter the current frame (no tearing, no early release).
REQ-024 Grant changes SHALL occur only at frame boundaries. gnt_a and gnt_b SHALL never both be high.
REQ-025 With tick=0, all state and outputs SHALL hold, except scan_done, which is 0.

Reset
REQ-026 While rst=0 at a clock edge, the next cycle SHALL have: state IDLE, an=1111, char=0000, gnt=00, scan_done=0, counters 0, pointer=A. This applies regardless of tick or requests.
REQ-027 Reset asserted mid-frame SHALL abort the frame immediately, with no scan_done pulse.

Structure
REQ-028 A shared package SHALL hold:
- the state encoding;
- the anode constants AN_OFF=1111 and the per-digit patterns;
- the nibble width of 4.
REQ-029 The BLANK/SHOW digit sequencer SHALL be a sub-module digit_scan_seq (inputs: tick, start; outputs: digit, an, frame_end). The arbiter and snapshot logic SHALL stay in the top.

Verification
REQ-030 Reset: rst=0 for 3 cycles, with req_a=1 and tick=1 → an=1111, char=0, gnt=00, scan_done=0 throughout.
REQ-031 Single owner (DWELL=2, BLANK=1, tick=1): req_a=1 with data_a=16'h1234 gives the following, and then repeats:
- gnt_a=1 one cycle later;
- an: 1111, 0111×2 with char=1;
- 1111, 1011×2 with char=2;
- 1111, 1101×2 with char=3;
- 1111, 1110×2 with char=4;
- scan_done on the 12th tick.
REQ-032 Tear-free: data_a changes to 16'hABCD during digit 2 → digits 1 and 0 still show 3 and 4; the next frame shows A, B, C, D.
REQ-033 Sharing (HOLD=2): req_a and req_b held high from IDLE → A granted for 2 frames, then B for 2, then A again. Each switch coincides with scan_done.
REQ-034 Release: req_a drops mid-frame with req_b=0 → the frame completes, then IDLE with an=1111 and gnt=00. With req_b=1 instead → gnt_b=1 right after scan_done.
REQ-035 Enable/reset: tick=0 for 5 cycles mid-SHOW → an, char and gnt frozen. Then rst=0 for 1 cycle → reset values the next cycle, with no scan_done pulse.
